dcpu16_mbus: RTL and testbench

- Two-master, one-slave memory arbiter for the DCPU16 core.
- Shares a single-ported memory between the CPU fetch/store bus (fs_*) and the operand bus (ab_*).
- Sits between dcpu16_cpu and the memory macro, and turns the core's two buses into one registered slave port.
- Arbitration is round-robin between the buses. A timeout watchdog guarantees every request is eventually acknowledged.

---
 rtl/dcpu16_pkg.sv | 19 +
 rtl/dcpu16_mbus_rr.sv | 31 +++
 rtl/dcpu16_mbus.sv | 149 ++++++++++++++
 tb/tb_dcpu16_mbus.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU16 memory-bus arbiter.
//   mbus_state_t : arbiter FSM encoding (IDLE / BUSY / RLSE)
//   GNT_*        : encodings of the gnt output (none / F master / A master)
//   DTI_ERR      : read data returned to a master whose slave cycle timed out
package dcpu16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RLSE = 2'd2
    } mbus_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_F    = 2'b01;
    localparam logic [1:0] GNT_A    = 2'b10;

    localparam logic [15:0] DTI_ERR = 16'hFFFF;

endpackage

// File: rtl/dcpu16_mbus_rr.sv
// Two-requester round-robin picker.
//   clk, rst      : clock, asynchronous active-low reset
//   req_f, req_a  : request lines of the F and A masters
//   upd           : commit the current pick as the last winner
//   pick_f, pick_a: one-hot (or zero) combinational winner
// On a tie the requester that did not win last time is picked. After reset
// the last winner is A, so F wins the first tie.
module dcpu16_mbus_rr (
    input  logic clk,
    input  logic rst,
    input  logic req_f,
    input  logic req_a,
    input  logic upd,
    output logic pick_f,
    output logic pick_a
);

    logic lst_a;   // 1: A won last, 0: F won last

    assign pick_f = req_f & (~req_a | lst_a);
    assign pick_a = req_a & (~req_f | ~lst_a);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lst_a <= 1'b1;
        end else if (upd) begin
            lst_a <= pick_a;
        end
    end

endmodule

// File: rtl/dcpu16_mbus.sv
// Two-master, one-slave memory arbiter between the DCPU16 core and the
// single-ported memory macro.
//   clk, rst          : clock, asynchronous active-low reset
//   fs_*              : F master (fetch/store) bus
//   ab_*              : A master (operand) bus
//   mm_*              : registered slave port towards the memory
//   gnt               : current owner (00 none, 01 F, 10 A)
//   err               : sticky watchdog flag, cleared only by reset
//   dbg_state         : current FSM state, for observation only
//
// Handshake: a master raises stb with wre/adr/dto valid and holds them until
// it sees its ack, a one-cycle pulse carrying read data on dti. The slave
// side is the same: mm_stb with frozen mm_wre/mm_adr/mm_dto until mm_ack.
// After every ack the arbiter spends one RLSE cycle without granting, which
// gives the master time to drop or change stb before arbitration resumes.
module dcpu16_mbus
    import dcpu16_pkg::*;
#(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs_stb,
    input  logic          fs_wre,
    input  logic [AW-1:0] fs_adr,
    input  logic [DW-1:0] fs_dto,
    output logic [DW-1:0] fs_dti,
    output logic          fs_ack,
    input  logic          ab_stb,
    input  logic          ab_wre,
    input  logic [AW-1:0] ab_adr,
    input  logic [DW-1:0] ab_dto,
    output logic [DW-1:0] ab_dti,
    output logic          ab_ack,
    output logic          mm_stb,
    output logic          mm_wre,
    output logic [AW-1:0] mm_adr,
    output logic [DW-1:0] mm_dto,
    input  logic [DW-1:0] mm_dti,
    input  logic          mm_ack,
    output logic [1:0]    gnt,
    output logic          err,
    output logic [1:0]    dbg_state
);

    // Abort fires when the counter has reached this value with no mm_ack.
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    mbus_state_t state, state_nx;
    logic [7:0]  cnt;
    logic        pick_f, pick_a;
    logic        rr_upd;
    logic        done_ok, done_tmo;

    assign dbg_state = state;

    dcpu16_mbus_rr u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_f  (fs_stb),
        .req_a  (ab_stb),
        .upd    (rr_upd),
        .pick_f (pick_f),
        .pick_a (pick_a)
    );

    always_comb begin
        state_nx = state;
        rr_upd   = 1'b0;
        done_ok  = 1'b0;
        done_tmo = 1'b0;
        case (state)
            IDLE: begin
                if (pick_f || pick_a) begin
                    rr_upd   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (mm_ack) begin
                    done_ok  = 1'b1;
                    state_nx = RLSE;
                end else if (cnt == TMO_LAST) begin
                    done_tmo = 1'b1;
                    state_nx = RLSE;
                end
            end
            RLSE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            gnt    <= GNT_NONE;
            mm_stb <= 1'b0;
            mm_wre <= 1'b0;
            mm_adr <= '0;
            mm_dto <= '0;
            fs_ack <= 1'b0;
            ab_ack <= 1'b0;
            fs_dti <= '0;
            ab_dti <= '0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            fs_ack <= 1'b0;
            ab_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (rr_upd) begin
                        mm_stb <= 1'b1;
                        mm_wre <= pick_f ? fs_wre : ab_wre;
                        mm_adr <= pick_f ? fs_adr : ab_adr;
                        mm_dto <= pick_f ? fs_dto : ab_dto;
                        gnt    <= pick_f ? GNT_F : GNT_A;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (done_ok || done_tmo) begin
                        mm_stb <= 1'b0;
                        gnt    <= GNT_NONE;
                        // Only the owner's dti/ack move; the other master's
                        // dti keeps its last value.
                        if (gnt == GNT_F) begin
                            fs_ack <= 1'b1;
                            fs_dti <= done_ok ? mm_dti : DW'(DTI_ERR);
                        end else begin
                            ab_ack <= 1'b1;
                            ab_dti <= done_ok ? mm_dti : DW'(DTI_ERR);
                        end
                        if (done_tmo) begin
                            err <= 1'b1;
                        end
                    end else if (cnt < TMO_LAST) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu16_mbus.sv
module tb_dcpu16_mbus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs_stb, fs_wre, ab_stb, ab_wre;
    logic [15:0] fs_adr, fs_dto, ab_adr, ab_dto;
    logic [15:0] fs_dti, ab_dti;
    logic        fs_ack, ab_ack;
    logic        mm_stb, mm_wre, mm_ack;
    logic [15:0] mm_adr, mm_dto, mm_dti;
    logic [1:0]  gnt, dbg_state;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    // slave model controls and memories
    int          slv_wait = 0;    // -1: never acknowledge
    bit          slv_rand = 1'b0; // pick a fresh 0..3 wait per transfer
    logic [15:0] slv_mem[256];
    logic [15:0] ref_mem[256];

    dcpu16_mbus #(.AW(16), .DW(16), .TMO(15)) dut (
        .clk(clk), .rst(rst),
        .fs_stb(fs_stb), .fs_wre(fs_wre), .fs_adr(fs_adr), .fs_dto(fs_dto),
        .fs_dti(fs_dti), .fs_ack(fs_ack),
        .ab_stb(ab_stb), .ab_wre(ab_wre), .ab_adr(ab_adr), .ab_dto(ab_dto),
        .ab_dti(ab_dti), .ab_ack(ab_ack),
        .mm_stb(mm_stb), .mm_wre(mm_wre), .mm_adr(mm_adr), .mm_dto(mm_dto),
        .mm_dti(mm_dti), .mm_ack(mm_ack),
        .gnt(gnt), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "simulation did not finish");
    end

    // ---------------- slave model ----------------
    initial begin
        int waited;
        int cur_wait;
        waited   = 0;
        cur_wait = 0;
        mm_ack   = 1'b0;
        mm_dti   = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst || mm_ack) begin
                mm_ack = 1'b0;
                waited = 0;
            end else if (mm_stb) begin
                if (waited == 0) cur_wait = slv_rand ? int'($urandom_range(0, 3)) : slv_wait;
                if (cur_wait >= 0 && waited >= cur_wait) begin
                    mm_ack = 1'b1;
                    mm_dti = slv_mem[mm_adr[7:0]];
                    if (mm_wre) slv_mem[mm_adr[7:0]] = mm_dto;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_masters();
        fs_stb = 1'b0; fs_wre = 1'b0;
        ab_stb = 1'b0; ab_wre = 1'b0;
    endtask

    task automatic apply_reset();
        idle_masters();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(input bit a_side, input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (a_side ? ab_ack : fs_ack) seen = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({mm_stb, mm_wre, mm_adr, mm_dto, fs_ack, ab_ack, fs_dti, ab_dti, gnt, err} !== 71'h0) begin
            n_err++;
            $display("FAIL reset_outputs got stb=%b wre=%b adr=%h dto=%h acks=%b%b dti=%h/%h gnt=%b err=%b exp all zero",
                     mm_stb, mm_wre, mm_adr, mm_dto, fs_ack, ab_ack, fs_dti, ab_dti, gnt, err);
        end
        n_vec++;
        if (dbg_state !== 2'd0) begin
            n_err++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_f_read();
        apply_reset();
        slv_rand = 1'b0; slv_wait = 0;
        fs_stb = 1'b1; fs_wre = 1'b0; fs_adr = 16'h0010; fs_dto = 16'h0;
        @(negedge clk);
        n_vec++;
        if ({mm_stb, mm_wre, mm_adr, gnt} !== {1'b1, 1'b0, 16'h0010, 2'b01}) begin
            n_err++;
            $display("FAIL fread_grant got stb=%b wre=%b adr=%h gnt=%b exp 1 0 0010 01", mm_stb, mm_wre, mm_adr, gnt);
        end
        @(negedge clk);
        n_vec++;
        if ({fs_ack, ab_ack, fs_dti, mm_stb} !== {1'b1, 1'b0, 16'h7C01, 1'b0}) begin
            n_err++;
            $display("FAIL fread_ack got fs_ack=%b ab_ack=%b fs_dti=%h mm_stb=%b exp 1 0 7c01 0", fs_ack, ab_ack, fs_dti, mm_stb);
        end
        fs_stb = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({fs_ack, ab_ack} !== 2'b00) begin
            n_err++; $display("FAIL fread_pulse got acks=%b%b exp 00", fs_ack, ab_ack);
        end
    endtask

    task automatic test_tie();
        logic [1:0] seq[$];
        logic [1:0] acks[$];
        logic [1:0] lastg;
        logic [1:0] exp_seq[5];
        exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        lastg = 2'b00;
        apply_reset();
        slv_rand = 1'b0; slv_wait = 0;
        fs_stb = 1'b1; fs_wre = 1'b0; fs_adr = 16'h0020;
        ab_stb = 1'b1; ab_wre = 1'b0; ab_adr = 16'h0030;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (gnt !== lastg) begin seq.push_back(gnt); lastg = gnt; end
            if (fs_ack) acks.push_back(2'b01);
            if (ab_ack) acks.push_back(2'b10);
        end
        n_vec++;
        if (seq.size() != 5) begin
            n_err++; $display("FAIL tie_seq_len got=%0d exp=5", seq.size());
        end
        for (int k = 0; k < 5 && k < seq.size(); k++) begin
            n_vec++;
            if (seq[k] !== exp_seq[k]) begin
                n_err++; $display("FAIL tie_gnt[%0d] got=%b exp=%b", k, seq[k], exp_seq[k]);
            end
        end
        n_vec++;
        if (acks.size() != 2 || acks[0] !== 2'b01 || acks[1] !== 2'b10) begin
            n_err++; $display("FAIL tie_ack_order got n=%0d first=%b exp n=2 order 01,10", acks.size(), (acks.size() > 0) ? acks[0] : 2'bxx);
        end
        idle_masters();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_a_write();
        int busy, n_ab, n_fs;
        busy = 0; n_ab = 0; n_fs = 0;
        apply_reset();
        slv_rand = 1'b0; slv_wait = 3;
        ab_stb = 1'b1; ab_wre = 1'b1; ab_adr = 16'h8000; ab_dto = 16'hBEEF;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mm_stb) begin
                busy++;
                n_vec++;
                if ({mm_wre, mm_adr, mm_dto} !== {1'b1, 16'h8000, 16'hBEEF}) begin
                    n_err++; $display("FAIL awrite_bus cyc=%0d got wre=%b adr=%h dto=%h exp 1 8000 beef", i, mm_wre, mm_adr, mm_dto);
                end
            end
            if (ab_ack) begin n_ab++; ab_stb = 1'b0; end
            if (fs_ack) n_fs++;
        end
        n_vec++;
        if (busy != 4) begin n_err++; $display("FAIL awrite_busy_cycles got=%0d exp=4", busy); end
        n_vec++;
        if (n_ab != 1 || n_fs != 0) begin
            n_err++; $display("FAIL awrite_acks got ab=%0d fs=%0d exp ab=1 fs=0", n_ab, n_fs);
        end
        idle_masters();
    endtask

    task automatic test_timeout();
        int  busy;
        bit  fin, seen;
        busy = 0; fin = 1'b0;
        apply_reset();
        slv_rand = 1'b0; slv_wait = -1;
        fs_stb = 1'b1; fs_wre = 1'b0; fs_adr = 16'h0040;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            if (mm_stb) begin
                busy++;
            end else if (busy > 0) begin
                fin = 1'b1;
                n_vec++;
                if ({fs_ack, ab_ack, fs_dti, err} !== {1'b1, 1'b0, 16'hFFFF, 1'b1}) begin
                    n_err++; $display("FAIL tmo_abort got fs_ack=%b ab_ack=%b fs_dti=%h err=%b exp 1 0 ffff 1", fs_ack, ab_ack, fs_dti, err);
                end
            end
        end
        n_vec++;
        if (!fin || busy != 15) begin n_err++; $display("FAIL tmo_cycles got=%0d done=%b exp=15", busy, fin); end
        fs_stb = 1'b0;
        slv_wait = 0;
        @(negedge clk);
        fs_stb = 1'b1; fs_adr = 16'h0041;
        wait_ack(1'b0, 10, seen);
        n_vec++;
        if (!seen || fs_dti !== ref_mem[8'h41] || err !== 1'b1) begin
            n_err++; $display("FAIL tmo_recover got seen=%b fs_dti=%h err=%b exp 1 %h 1", seen, fs_dti, err, ref_mem[8'h41]);
        end
        fs_stb = 1'b0;
        @(negedge clk);
    endtask

    // runs straight after test_timeout so err is still set going in
    task automatic test_reset_mid();
        bit seen;
        slv_rand = 1'b0; slv_wait = -1;
        fs_stb = 1'b1; fs_adr = 16'h0050;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (mm_stb !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got mm_stb=%b exp 1", mm_stb); end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({mm_stb, gnt, fs_ack, ab_ack, err} !== 5'b0) begin
            n_err++; $display("FAIL rstmid_async got stb=%b gnt=%b acks=%b%b err=%b exp all 0", mm_stb, gnt, fs_ack, ab_ack, err);
        end
        idle_masters();
        slv_wait = 0;
        @(negedge clk);
        n_vec++;
        if ({mm_stb, fs_ack} !== 2'b00) begin n_err++; $display("FAIL rstmid_noack got stb=%b fs_ack=%b exp 00", mm_stb, fs_ack); end
        rst = 1'b1;
        @(negedge clk);
        fs_stb = 1'b1; fs_adr = 16'h0051;
        ab_stb = 1'b1; ab_adr = 16'h0052;
        @(negedge clk);
        n_vec++;
        if (gnt !== 2'b01) begin n_err++; $display("FAIL rstmid_tie got gnt=%b exp 01", gnt); end
        wait_ack(1'b0, 5, seen);
        fs_stb = 1'b0;
        wait_ack(1'b1, 8, seen);
        idle_masters();
        @(negedge clk);
    endtask

    task automatic test_hold();
        int  busy;
        bit  fin;
        busy = 0; fin = 1'b0;
        apply_reset();
        slv_rand = 1'b0; slv_wait = 5;
        fs_stb = 1'b1; fs_wre = 1'b0; fs_adr = 16'h0001;
        for (int i = 0; i < 15 && !fin; i++) begin
            @(negedge clk);
            if (mm_stb) begin
                busy++;
                n_vec++;
                if (mm_adr !== 16'h0001) begin n_err++; $display("FAIL hold_adr cyc=%0d got=%h exp=0001", i, mm_adr); end
                fs_adr = 16'h0002;
            end
            if (fs_ack) fin = 1'b1;
        end
        n_vec++;
        if (!fin || busy != 6) begin n_err++; $display("FAIL hold_cycles got=%0d done=%b exp=6", busy, fin); end
        idle_masters();
        @(negedge clk);
    endtask

    task automatic test_random();
        bit          pf, pa, fw, aw, exp_w, last_a, prev;
        logic [15:0] fa, fd, aa, ad, exp_d;
        int          owner, done, cyc;
        pf = 0; pa = 0; fw = 0; aw = 0; exp_w = 0; prev = 0; last_a = 1'b1;
        fa = 0; fd = 0; aa = 0; ad = 0; exp_d = 0; owner = 0; done = 0;
        apply_reset();
        slv_rand = 1'b1;
        for (cyc = 0; cyc < 3000 && done < 60; cyc++) begin
            @(negedge clk);
            if (mm_stb && !prev) begin
                int win;
                logic [15:0] wa;
                win = (pf && pa) ? (last_a ? 1 : 2) : (pf ? 1 : (pa ? 2 : 0));
                wa  = (win == 1) ? fa : aa;
                n_vec++;
                if (win == 0 || gnt !== 2'(win) || mm_adr !== wa || mm_wre !== ((win == 1) ? fw : aw)
                    || (mm_wre && mm_dto !== ((win == 1) ? fd : ad))) begin
                    n_err++;
                    $display("FAIL rand_grant cyc=%0d got gnt=%b adr=%h wre=%b dto=%h exp owner=%0d adr=%h",
                             cyc, gnt, mm_adr, mm_wre, mm_dto, win, wa);
                end
                owner  = win;
                exp_w  = (win == 1) ? fw : aw;
                exp_d  = ref_mem[wa[7:0]];
                if (exp_w) ref_mem[wa[7:0]] = (win == 1) ? fd : ad;
                last_a = (win == 2);
            end
            if (fs_ack || ab_ack) begin
                n_vec++;
                if ((fs_ack && ab_ack) || (fs_ack && owner != 1) || (ab_ack && owner != 2)
                    || (!exp_w && (fs_ack ? fs_dti : ab_dti) !== exp_d)) begin
                    n_err++;
                    $display("FAIL rand_ack cyc=%0d got acks=%b%b dti=%h exp owner=%0d dti=%h",
                             cyc, fs_ack, ab_ack, fs_ack ? fs_dti : ab_dti, owner, exp_d);
                end
                if (fs_ack) pf = 1'b0;
                if (ab_ack) pa = 1'b0;
                owner = 0;
                done++;
            end
            prev = mm_stb;
            if (!pf && $urandom_range(0, 1) == 1) begin
                pf = 1'b1; fa = 16'($urandom_range(0, 255)); fw = 1'($urandom_range(0, 1)); fd = 16'($urandom);
            end
            if (!pa && $urandom_range(0, 1) == 1) begin
                pa = 1'b1; aa = 16'($urandom_range(0, 255)); aw = 1'($urandom_range(0, 1)); ad = 16'($urandom);
            end
            fs_stb = pf; fs_adr = fa; fs_wre = fw; fs_dto = fd;
            ab_stb = pa; ab_adr = aa; ab_wre = aw; ab_dto = ad;
        end
        n_vec++;
        if (done < 60) begin n_err++; $display("FAIL rand_progress got=%0d exp>=60 transfers", done); end
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL rand_err got=%b exp 0", err); end
        idle_masters();
        slv_rand = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = 16'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        slv_mem[8'h10] = 16'h7C01;
        ref_mem[8'h10] = 16'h7C01;
        idle_masters();
        fs_adr = 16'h0; fs_dto = 16'h0; ab_adr = 16'h0; ab_dto = 16'h0;

        test_reset();
        test_f_read();
        test_tie();
        test_a_write();
        test_timeout();
        test_reset_mid();
        test_hold();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
